// File: rtl/bus_datapath_pkg.sv
// Shared types for the bus datapath: bus-source selects, ALU opcodes,
// condition codes and the memory-interface FSM states.
package bus_datapath_pkg;

  typedef enum logic [2:0] {
    SRC_RF  = 3'd0,
    SRC_Z   = 3'd1,
    SRC_PC  = 3'd2,
    SRC_MDR = 3'd3,
    SRC_EXT = 3'd4
  } bus_src_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_NEG  = 4'd8,
    ALU_PASS = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    COND_ZERO    = 2'd0,
    COND_NONZERO = 2'd1,
    COND_POS     = 2'd2,
    COND_NEG     = 2'd3
  } cond_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/bus_datapath_memif.sv
// Memory-cycle controller for the bus datapath.
// A start pulse in IDLE latches address, direction and write data, then
// holds mem_req until mem_ack; one DONE cycle follows before IDLE.
// Optional feature: define MEM_TIMEOUT_EN to abandon a request after
// TIMEOUT cycles without mem_ack (mem_err pulses for one cycle).
// Ports:
//   clk, clr            clock, asynchronous active-low reset
//   start_rd, start_wr  start pulses (read wins when both are high)
//   addr, wdata         MAR slice and MDR, captured on leaving IDLE
//   mem_ack             memory acknowledge (honoured only in REQ)
//   mem_req, mem_we     request strobe and direction of the cycle in flight
//   mem_addr, mem_wdata latched address / write data
//   busy                high in REQ and DONE
//   mem_err             one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)
//   mdr_load            combinational: load MDR from mem_rdata this edge
module bus_datapath_memif
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              mem_err,
  output logic              mdr_load
);

  mem_state_e state;

  // A read completes on the edge that leaves REQ with mem_ack high.
  assign mdr_load = (state == MEM_REQ) && mem_ack && !mem_we;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= MEM_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      mem_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (start_rd || start_wr) begin
            state     <= MEM_REQ;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= !start_rd;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            cnt       <= '0;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            state   <= MEM_DONE;
            mem_req <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Give up: MDR is left untouched, the error is flagged once.
            state   <= MEM_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEM_DONE: begin
          state <= MEM_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= MEM_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
`else
  // No timeout: a request waits for mem_ack indefinitely.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign mem_err = 1'b0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= MEM_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (start_rd || start_wr) begin
            state     <= MEM_REQ;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= !start_rd;
            mem_addr  <= addr;
            mem_wdata <= wdata;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            state   <= MEM_DONE;
            mem_req <= 1'b0;
          end
        end
        MEM_DONE: begin
          state <= MEM_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= MEM_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: rtl/bus_datapath_p.sv
// Single-bus processor datapath: register file, Y/Z ALU registers, PC,
// MAR/MDR and a condition flag, all loaded from one combinational bus.
// Memory cycles are run by bus_datapath_memif.
// Optional feature: MEM_TIMEOUT_EN (memory request timeout, see memif).
// Ports:
//   clk, clr                   clock, asynchronous active-low reset
//   bus_src                    0 RF, 1 Z, 2 PC, 3 MDR, 4 ext_in, 5-7 zero
//   rf_rd_idx/rf_wr_idx/rf_wr_en register-file read / write control
//   r0_zero                    RF index 0 reads as zero on the bus
//   Yin Zin PCin MARin MDRin CONin, pc_inc  register load enables
//   alu_op, cond, ext_in       ALU opcode, condition select, external data
//   mem_rd, mem_wr, busy       memory cycle start / in progress
//   mem_req mem_we mem_addr mem_wdata mem_rdata mem_ack  memory handshake
//   bus_out, con_out, mem_err  bus value, condition flag, timeout pulse
module bus_datapath_p
  import bus_datapath_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [2:0]        bus_src,
  input  logic [RIDX_W-1:0] rf_rd_idx,
  input  logic [RIDX_W-1:0] rf_wr_idx,
  input  logic              rf_wr_en,
  input  logic              r0_zero,
  input  logic              Yin,
  input  logic              Zin,
  input  logic              PCin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              CONin,
  input  logic              pc_inc,
  input  logic [3:0]        alu_op,
  input  logic [1:0]        cond,
  input  logic [DATA_W-1:0] ext_in,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] bus_out,
  output logic              con_out,
  output logic              mem_err
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] y, z, pc, mar, mdr;
  logic [DATA_W-1:0] bus, alu_res;
  logic              mdr_load;

  function automatic logic [DATA_W-1:0] alu_f(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [SH_W-1:0]          sh;
    logic signed [DATA_W-1:0] a_s;
    sh  = b[SH_W-1:0];
    a_s = a;
    case (op)
      ALU_ADD:  alu_f = a + b;
      ALU_SUB:  alu_f = a - b;
      ALU_AND:  alu_f = a & b;
      ALU_OR:   alu_f = a | b;
      ALU_SHL:  alu_f = a << sh;
      ALU_SHR:  alu_f = a >> sh;
      ALU_SRA:  alu_f = a_s >>> sh;
      ALU_NOT:  alu_f = ~b;
      ALU_NEG:  alu_f = '0 - b;
      ALU_PASS: alu_f = b;
      default:  alu_f = '0;
    endcase
  endfunction

  function automatic logic cond_f(input logic [1:0] c, input logic [DATA_W-1:0] b);
    case (c)
      COND_ZERO:    cond_f = (b == '0);
      COND_NONZERO: cond_f = (b != '0);
      COND_POS:     cond_f = !b[DATA_W-1];
      default:      cond_f = b[DATA_W-1];
    endcase
  endfunction

  always_comb begin
    bus = '0;
    case (bus_src)
      SRC_RF:  bus = (r0_zero && rf_rd_idx == '0) ? '0 : rf[rf_rd_idx];
      SRC_Z:   bus = z;
      SRC_PC:  bus = pc;
      SRC_MDR: bus = mdr;
      SRC_EXT: bus = ext_in;
      default: bus = '0;
    endcase
  end

  assign bus_out = bus;
  assign alu_res = alu_f(alu_op, y, bus);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      y       <= '0;
      z       <= '0;
      pc      <= '0;
      mar     <= '0;
      mdr     <= '0;
      con_out <= 1'b0;
    end else begin
      if (rf_wr_en) rf[rf_wr_idx] <= bus;
      if (Yin)      y <= bus;
      if (Zin)      z <= alu_res;
      // An explicit PC load overrides the increment.
      if (PCin)        pc <= bus;
      else if (pc_inc) pc <= pc + 1'b1;
      if (MARin)    mar <= bus;
      // Returning read data takes priority over a bus load of MDR.
      if (mdr_load)   mdr <= mem_rdata;
      else if (MDRin) mdr <= bus;
      if (CONin)    con_out <= cond_f(cond, bus);
    end
  end

  if (ADDR_W < DATA_W) begin : g_mar_hi
    logic unused_mar_hi;
    assign unused_mar_hi = ^mar[DATA_W-1:ADDR_W];
  end

  bus_datapath_memif #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) u_memif (
    .clk      (clk),
    .clr      (clr),
    .start_rd (mem_rd),
    .start_wr (mem_wr),
    .addr     (mar[ADDR_W-1:0]),
    .wdata    (mdr),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .mem_err  (mem_err),
    .mdr_load (mdr_load)
  );

endmodule
